// File: rtl/cga_pkg.sv
// Shared types and constants for the CGA VRAM display fetch path.
package cga_pkg;

  // VRAM is byte addressed; a text cell is one 16-bit word (char, attr).
  localparam int VRAM_AW = 14;
  localparam int WORD_AW = VRAM_AW - 1;
  localparam int PIX_AW  = 19;
  localparam int PAIR_W  = 16;

  typedef enum logic [1:0] {
    IDLE,
    CHAR,
    ATTR,
    STALL
  } fetch_state_e;

  typedef struct packed {
    logic [7:0] chr;
    logic [7:0] attr;
  } fetch_pair_t;

  // Byte address of the first (b=0) or second (b=1) byte of a cell.
  function automatic logic [VRAM_AW-1:0] cell_byte_addr(input logic [WORD_AW-1:0] hi,
                                                        input logic b);
    return {hi, b};
  endfunction

endpackage

// File: rtl/cga_fetch_fifo.sv
// Two-entry FIFO of fetched byte pairs; push and pop may share a cycle.
module cga_fetch_fifo
  import cga_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic [PAIR_W-1:0] push_data,
  input  logic              pop,
  output logic [PAIR_W-1:0] head,
  output logic [1:0]        count
);

  logic [1:0][PAIR_W-1:0] mem;
  logic                   wr_ptr;
  logic                   rd_ptr;
  logic                   do_push;
  logic                   do_pop;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign head    = mem[rd_ptr];

  // Storage, pointers and occupancy; flush empties and scrubs stale pairs.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      mem    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/cga_vram_fetch.sv
// Display-side VRAM reader: walks the cells of a scanline, issues byte
// reads on the pixel port and hands (char, attr) pairs to the shifter.
// Optional: define CGA_GFX_FETCH_EN to add gfx_mode/odd_line ports for
// interleaved graphics-byte fetch.
module cga_vram_fetch
  import cga_pkg::*;
#(
  parameter int MAX_COLS = 80,
  localparam int COL_W   = $clog2(MAX_COLS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              row_advance,
  input  logic              line_start,
  input  logic [12:0]       start_addr,
  input  logic [COL_W-1:0]  hdisp,
`ifdef CGA_GFX_FETCH_EN
  input  logic              gfx_mode,
  input  logic              odd_line,
`endif
  output logic [PIX_AW-1:0] pixel_addr,
  output logic              pixel_read,
  input  logic [7:0]        pixel_data,
  output logic [7:0]        char_out,
  output logic [7:0]        attr_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              line_busy
);

  fetch_state_e       state, state_nxt;
  logic [WORD_AW-1:0] row_base;
  logic [WORD_AW-1:0] word_addr;
  logic [WORD_AW-1:0] addr_hi;
  logic [COL_W-1:0]   col;
  logic [COL_W-1:0]   col_inc;
  logic [VRAM_AW-1:0] addr_cur;
  logic [VRAM_AW-1:0] addr_q;
  logic               issue_char, issue_attr;
  logic               rd_char_q, rd_attr_q, rd_last_q;
  logic [7:0]         char_lat;
  logic               last_cell, has_cells;
  logic               flush, push, pop;
  logic [1:0]         occ;
  logic [2:0]         occ_nxt;
  fetch_pair_t        push_pair, head_pair;
  logic [PAIR_W-1:0]  head_bits;

  assign word_addr = row_base + WORD_AW'(col);
  assign col_inc   = col + 1'b1;
  assign last_cell = (col_inc >= hdisp);
  assign has_cells = (hdisp != '0);

  // A restart only throws work away when the previous line is still live.
  assign flush = line_start && line_busy;
  assign push  = rd_attr_q;
  assign pop   = out_valid && out_ready;
  assign occ_nxt = {1'b0, occ} + {2'b00, push} - {2'b00, pop};

  // Upper address bits: text word index, or bank-interleaved graphics row.
  always_comb begin
    addr_hi = word_addr;
`ifdef CGA_GFX_FETCH_EN
    if (gfx_mode) addr_hi = {odd_line, word_addr[WORD_AW-2:0]};
`endif
  end

  assign addr_cur   = cell_byte_addr(addr_hi, issue_attr);
  assign pixel_read = issue_char || issue_attr;
  assign pixel_addr = {{(PIX_AW-VRAM_AW){1'b0}}, pixel_read ? addr_cur : addr_q};

  // Next state and issue strobes. A new CHAR is allowed only if the pair
  // it starts still fits once everything already fetched has landed.
  always_comb begin
    state_nxt  = state;
    issue_char = 1'b0;
    issue_attr = 1'b0;
    unique case (state)
      IDLE: state_nxt = IDLE;
      CHAR: begin
        issue_char = 1'b1;
        state_nxt  = ATTR;
      end
      ATTR: begin
        issue_attr = 1'b1;
        // The pair issued now is still in flight when the next CHAR would go.
        if (last_cell)              state_nxt = IDLE;
        else if (occ_nxt == 3'd0)   state_nxt = CHAR;
        else                        state_nxt = STALL;
      end
      STALL: if (occ_nxt < 3'd2) state_nxt = CHAR;
      default: state_nxt = IDLE;
    endcase
    if (line_start) begin
      if (!has_cells)                      state_nxt = IDLE;
      else if (flush || occ_nxt < 3'd2)    state_nxt = CHAR;
      else                                 state_nxt = STALL;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Row base: frame_start reloads, row_advance steps by one line of cells.
  always_ff @(posedge clk) begin
    if (reset)            row_base <= '0;
    else if (frame_start) row_base <= start_addr;
    else if (row_advance) row_base <= row_base + WORD_AW'(hdisp);
  end

  // Column counter: cleared per line, bumped once per completed cell.
  always_ff @(posedge clk) begin
    if (reset || line_start) col <= '0;
    else if (issue_attr)     col <= col_inc;
  end

  // Read-return tracking; a restart drops whatever is still in flight.
  always_ff @(posedge clk) begin
    if (reset || line_start) begin
      rd_char_q <= 1'b0;
      rd_attr_q <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      rd_char_q <= issue_char;
      rd_attr_q <= issue_attr;
      rd_last_q <= issue_attr && last_cell;
    end
  end

  // Hold the first byte of a pair until its partner returns.
  always_ff @(posedge clk) begin
    if (reset)          char_lat <= '0;
    else if (rd_char_q) char_lat <= pixel_data;
  end

  // Keep the last issued address visible while the port is idle.
  always_ff @(posedge clk) begin
    if (reset)           addr_q <= '0;
    else if (pixel_read) addr_q <= addr_cur;
  end

  // Busy from line_start until the final attr byte has been captured.
  always_ff @(posedge clk) begin
    if (reset)                       line_busy <= 1'b0;
    else if (line_start)             line_busy <= has_cells;
    else if (rd_attr_q && rd_last_q) line_busy <= 1'b0;
  end

  assign push_pair = '{chr: char_lat, attr: pixel_data};

  cga_fetch_fifo u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .push_data (push_pair),
    .pop       (pop),
    .head      (head_bits),
    .count     (occ)
  );

  assign head_pair = fetch_pair_t'(head_bits);
  assign char_out  = head_pair.chr;
  assign attr_out  = head_pair.attr;
  assign out_valid = (occ != 2'd0);

endmodule

// File: tb/tb_cga_vram_fetch.sv
// Self-checking bench for cga_vram_fetch: VRAM model, output logging and
// a cell-level reference model of the expected address/pair streams.
module tb_cga_vram_fetch;

  logic        clk;
  logic        reset;
  logic        frame_start, row_advance, line_start;
  logic [12:0] start_addr;
  logic [6:0]  hdisp;
  logic [18:0] pixel_addr;
  logic        pixel_read;
  logic [7:0]  pixel_data;
  logic [7:0]  char_out, attr_out;
  logic        out_valid, out_ready, line_busy;
`ifdef CGA_GFX_FETCH_EN
  logic        gfx_mode, odd_line;
`endif

  cga_vram_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .row_advance (row_advance),
    .line_start  (line_start),
    .start_addr  (start_addr),
    .hdisp       (hdisp),
`ifdef CGA_GFX_FETCH_EN
    .gfx_mode    (gfx_mode),
    .odd_line    (odd_line),
`endif
    .pixel_addr  (pixel_addr),
    .pixel_read  (pixel_read),
    .pixel_data  (pixel_data),
    .char_out    (char_out),
    .attr_out    (attr_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .line_busy   (line_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0]  vram [16384];
  logic [18:0] addr_log [$];
  logic [15:0] pair_log [$];
  logic [18:0] exp_addr [$];
  logic [15:0] exp_pair [$];
  int          m_rb;
  int          cyc = 0;
  int          first_read_cyc, last_read_cyc, busy_fall_cyc, busy_cycles;
  logic        busy_prev = 1'b0;

  // VRAM: one-cycle read latency, garbage on the bus when nothing was read.
  always @(posedge clk)
    pixel_data <= pixel_read ? vram[pixel_addr[13:0]] : 8'($urandom);

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (pixel_read) begin
      if (addr_log.size() == 0) first_read_cyc = cyc;
      addr_log.push_back(pixel_addr);
      last_read_cyc = cyc;
    end
    if (out_valid && out_ready) pair_log.push_back({char_out, attr_out});
    if (line_busy) busy_cycles++;
    if (busy_prev && !line_busy) busy_fall_cyc = cyc;
    busy_prev = line_busy;
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_frame(input logic [12:0] sa);
    start_addr = sa; frame_start = 1'b1; tick(); frame_start = 1'b0;
    m_rb = int'(sa);
  endtask

  task automatic do_row_adv();
    row_advance = 1'b1; tick(); row_advance = 1'b0;
    m_rb = (m_rb + int'(hdisp)) % 8192;
  endtask

  task automatic start_line();
    addr_log.delete(); pair_log.delete();
    line_start = 1'b1; tick(); line_start = 1'b0;
  endtask

  task automatic wait_done(input int max, input bit rnd_ready, output bit to);
    int n = 0;
    while (line_busy && n < max) begin
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      tick(); n++;
    end
    to = line_busy;
    out_ready = 1'b1;
    repeat (4) tick();
  endtask

  // Reference model: cell c of the line lives at word (row_base + c) mod 8K.
  task automatic build_exp(input int rb, input int n);
    exp_addr.delete(); exp_pair.delete();
    for (int c = 0; c < n; c++) begin
      int w = (rb + c) % 8192;
      exp_addr.push_back(19'(2 * w));
      exp_addr.push_back(19'(2 * w + 1));
      exp_pair.push_back({vram[2 * w], vram[2 * w + 1]});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++; if (pixel_addr !== 19'h0) begin errors++; $display("FAIL reset_pixel_addr got %h want 0", pixel_addr); end
    checks++; if (pixel_read !== 1'b0) begin errors++; $display("FAIL reset_pixel_read got %b want 0", pixel_read); end
    checks++; if (char_out !== 8'h0 || attr_out !== 8'h0) begin errors++; $display("FAIL reset_pair got %h/%h want 0/0", char_out, attr_out); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (line_busy !== 1'b0) begin errors++; $display("FAIL reset_line_busy got %b want 0", line_busy); end
    reset = 1'b0;
    addr_log.delete();
    repeat (3) tick();
    checks++; if (addr_log.size() != 0) begin errors++; $display("FAIL reset_idle_reads got %0d want 0", addr_log.size()); end
    m_rb = 0;
  endtask

  task automatic test_basic();
    bit to;
    hdisp = 7'd3; out_ready = 1'b1;
    do_frame(13'h010);
    build_exp(m_rb, 3);
    start_line();
    wait_done(100, 1'b0, to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout line_busy stuck high"); end
    checks++; if (addr_log.size() != 6) begin errors++; $display("FAIL basic_addr_count got %0d want 6", addr_log.size()); end
    for (int i = 0; i < 6 && i < addr_log.size(); i++) begin
      checks++; if (addr_log[i] !== 19'(32 + i)) begin errors++; $display("FAIL basic_addr[%0d] got %h want %h", i, addr_log[i], 19'(32 + i)); end
    end
    checks++; if (pair_log.size() != 3) begin errors++; $display("FAIL basic_pair_count got %0d want 3", pair_log.size()); end
    for (int i = 0; i < 3 && i < pair_log.size(); i++) begin
      checks++; if (pair_log[i] !== exp_pair[i]) begin errors++; $display("FAIL basic_pair[%0d] got %h want %h", i, pair_log[i], exp_pair[i]); end
    end
    checks++; if (last_read_cyc - first_read_cyc != 5) begin errors++; $display("FAIL basic_throughput got span %0d want 5", last_read_cyc - first_read_cyc); end
    checks++; if (busy_fall_cyc != last_read_cyc + 2) begin errors++; $display("FAIL basic_busy_fall got cycle %0d want %0d", busy_fall_cyc, last_read_cyc + 2); end
  endtask

  task automatic test_backpressure();
    bit to;
    hdisp = 7'd5; out_ready = 1'b0;
    do_frame(13'($urandom));
    build_exp(m_rb, 5);
    start_line();
    repeat (20) tick();
    checks++; if (addr_log.size() != 4) begin errors++; $display("FAIL bp_stall_reads got %0d want 4", addr_log.size()); end
    checks++; if (pixel_read !== 1'b0) begin errors++; $display("FAIL bp_stall_read got %b want 0", pixel_read); end
    checks++; if (out_valid !== 1'b1 || line_busy !== 1'b1) begin errors++; $display("FAIL bp_stall_flags got valid=%b busy=%b want 1/1", out_valid, line_busy); end
    checks++; if (pair_log.size() != 0) begin errors++; $display("FAIL bp_no_pop got %0d want 0", pair_log.size()); end
    out_ready = 1'b1;
    wait_done(200, 1'b0, to);
    checks++; if (to) begin errors++; $display("FAIL bp_timeout line_busy stuck high"); end
    checks++; if (addr_log.size() != 10) begin errors++; $display("FAIL bp_addr_count got %0d want 10", addr_log.size()); end
    for (int i = 0; i < exp_addr.size() && i < addr_log.size(); i++) begin
      checks++; if (addr_log[i] !== exp_addr[i]) begin errors++; $display("FAIL bp_addr[%0d] got %h want %h", i, addr_log[i], exp_addr[i]); end
    end
    checks++; if (pair_log.size() != 5) begin errors++; $display("FAIL bp_pair_count got %0d want 5", pair_log.size()); end
    for (int i = 0; i < 5 && i < pair_log.size(); i++) begin
      checks++; if (pair_log[i] !== exp_pair[i]) begin errors++; $display("FAIL bp_pair[%0d] got %h want %h", i, pair_log[i], exp_pair[i]); end
    end
  endtask

  task automatic test_wrap();
    bit to;
    logic [18:0] want [8];
    want = '{19'h3FFC, 19'h3FFD, 19'h3FFE, 19'h3FFF, 19'h0000, 19'h0001, 19'h0002, 19'h0003};
    hdisp = 7'd4; out_ready = 1'b1;
    do_frame(13'h1FFE);
    build_exp(m_rb, 4);
    start_line();
    wait_done(100, 1'b0, to);
    checks++; if (to || addr_log.size() != 8) begin errors++; $display("FAIL wrap_addr_count got %0d want 8", addr_log.size()); end
    for (int i = 0; i < 8 && i < addr_log.size(); i++) begin
      checks++; if (addr_log[i] !== want[i]) begin errors++; $display("FAIL wrap_addr[%0d] got %h want %h", i, addr_log[i], want[i]); end
    end
    for (int i = 0; i < 4 && i < pair_log.size(); i++) begin
      checks++; if (pair_log[i] !== exp_pair[i]) begin errors++; $display("FAIL wrap_pair[%0d] got %h want %h", i, pair_log[i], exp_pair[i]); end
    end
    do_row_adv();
    build_exp(m_rb, 4);
    start_line();
    wait_done(100, 1'b0, to);
    checks++; if (to || addr_log.size() != 8) begin errors++; $display("FAIL wrap_row2_count got %0d want 8", addr_log.size()); end
    checks++; if (addr_log.size() == 0 || addr_log[0] !== 19'h0004) begin errors++; $display("FAIL wrap_row2_first got %h want 00004", addr_log.size() ? addr_log[0] : 19'h7FFFF); end
    for (int i = 0; i < exp_addr.size() && i < addr_log.size(); i++) begin
      checks++; if (addr_log[i] !== exp_addr[i] || addr_log[i][18:14] !== 5'h0) begin errors++; $display("FAIL wrap_row2_addr[%0d] got %h want %h", i, addr_log[i], exp_addr[i]); end
    end
  endtask

  task automatic test_abort();
    bit to;
    int n = 0;
    logic [12:0] sa2;
    hdisp = 7'd10; out_ready = 1'b1;
    do_frame(13'($urandom));
    start_line();
    while (addr_log.size() < 5 && n < 50) begin tick(); n++; end
    checks++; if (addr_log.size() != 5) begin errors++; $display("FAIL abort_reach_cell3 got %0d reads want 5", addr_log.size()); end
    sa2 = 13'(m_rb + 100 + int'($urandom_range(0, 1000)));
    start_addr = sa2; frame_start = 1'b1; line_start = 1'b1;
    tick();
    frame_start = 1'b0; line_start = 1'b0;
    addr_log.delete(); pair_log.delete();
    m_rb = int'(sa2);
    build_exp(m_rb, 10);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_flush got out_valid=%b want 0", out_valid); end
    checks++; if (pixel_read !== 1'b1 || pixel_addr !== exp_addr[0]) begin errors++; $display("FAIL abort_restart_addr got read=%b addr=%h want 1/%h", pixel_read, pixel_addr, exp_addr[0]); end
    wait_done(200, 1'b0, to);
    checks++; if (to || addr_log.size() != 20) begin errors++; $display("FAIL abort_addr_count got %0d want 20", addr_log.size()); end
    checks++; if (pair_log.size() != 10) begin errors++; $display("FAIL abort_pair_count got %0d want 10", pair_log.size()); end
    for (int i = 0; i < 10 && i < pair_log.size(); i++) begin
      checks++; if (pair_log[i] !== exp_pair[i]) begin errors++; $display("FAIL abort_pair[%0d] got %h want %h", i, pair_log[i], exp_pair[i]); end
    end
  endtask

  task automatic test_strobes();
    bit to;
    logic [12:0] sa;
    sa = 13'($urandom);
    hdisp = 7'd7; out_ready = 1'b1;
    start_addr = sa; frame_start = 1'b1; row_advance = 1'b1;
    tick();
    frame_start = 1'b0; row_advance = 1'b0;
    m_rb = int'(sa);
    hdisp = 7'd1;
    build_exp(m_rb, 1);
    start_line();
    wait_done(50, 1'b0, to);
    checks++; if (to || addr_log.size() != 2) begin errors++; $display("FAIL strobe_addr_count got %0d want 2", addr_log.size()); end
    checks++; if (addr_log.size() == 0 || addr_log[0] !== exp_addr[0]) begin errors++; $display("FAIL strobe_row_base got %h want %h", addr_log.size() ? addr_log[0] : 19'h7FFFF, exp_addr[0]); end
    hdisp = 7'd0;
    busy_cycles = 0;
    start_line();
    repeat (10) tick();
    checks++; if (addr_log.size() != 0) begin errors++; $display("FAIL hdisp0_reads got %0d want 0", addr_log.size()); end
    checks++; if (busy_cycles != 0 || line_busy !== 1'b0) begin errors++; $display("FAIL hdisp0_busy got %0d busy cycles want 0", busy_cycles); end
  endtask

  task automatic test_random();
    bit to;
    int n;
    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 1) == 1) do_frame(13'($urandom));
      else do_row_adv();
      n = int'($urandom_range(1, 24));
      hdisp = 7'(n);
      build_exp(m_rb, n);
      start_line();
      wait_done(1000, 1'b1, to);
      checks++; if (to) begin errors++; $display("FAIL rand%0d_timeout line_busy stuck high", it); end
      checks++; if (addr_log.size() != 2 * n || pair_log.size() != n) begin errors++; $display("FAIL rand%0d_counts got %0d/%0d want %0d/%0d", it, addr_log.size(), pair_log.size(), 2 * n, n); end
      for (int i = 0; i < exp_addr.size() && i < addr_log.size(); i++) begin
        checks++; if (addr_log[i] !== exp_addr[i]) begin errors++; $display("FAIL rand%0d_addr[%0d] got %h want %h", it, i, addr_log[i], exp_addr[i]); end
      end
      for (int i = 0; i < n && i < pair_log.size(); i++) begin
        checks++; if (pair_log[i] !== exp_pair[i]) begin errors++; $display("FAIL rand%0d_pair[%0d] got %h want %h", it, i, pair_log[i], exp_pair[i]); end
      end
    end
  endtask

`ifdef CGA_GFX_FETCH_EN
  task automatic test_gfx();
    bit to;
    gfx_mode = 1'b1; odd_line = 1'b1;
    hdisp = 7'd2; out_ready = 1'b1;
    do_frame(13'h0000);
    start_line();
    wait_done(100, 1'b0, to);
    checks++; if (to || addr_log.size() != 4) begin errors++; $display("FAIL gfx_addr_count got %0d want 4", addr_log.size()); end
    for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
      checks++; if (addr_log[i] !== 19'(32'h2000 + i)) begin errors++; $display("FAIL gfx_addr[%0d] got %h want %h", i, addr_log[i], 19'(32'h2000 + i)); end
    end
    for (int i = 0; i < 2 && i < pair_log.size(); i++) begin
      checks++; if (pair_log[i] !== {vram[16'h2000 + 2 * i], vram[16'h2001 + 2 * i]}) begin errors++; $display("FAIL gfx_pair[%0d] got %h", i, pair_log[i]); end
    end
    gfx_mode = 1'b0; odd_line = 1'b0;
  endtask
`endif

  initial begin
    for (int i = 0; i < 16384; i++) vram[i] = 8'($urandom);
    reset = 1'b1; frame_start = 1'b0; row_advance = 1'b0; line_start = 1'b0;
    start_addr = '0; hdisp = '0; out_ready = 1'b0;
`ifdef CGA_GFX_FETCH_EN
    gfx_mode = 1'b0; odd_line = 1'b0;
`endif
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_abort();
    test_strobes();
    test_random();
`ifdef CGA_GFX_FETCH_EN
    test_gfx();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
